// File: rtl/isa_pkg.sv
// Shared ISA constants for the 9-bit instruction word: op codes, opcode
// prefixes and field widths, used by both the encoder and the decoder.
package isa_pkg;

    typedef enum logic [3:0] {
        OP_MOV  = 4'd0,
        OP_ALU1 = 4'd1,
        OP_ALU2 = 4'd2,
        OP_ALU3 = 4'd3,
        OP_ALU4 = 4'd4,
        OP_SLI  = 4'd5,
        OP_SRI  = 4'd6,
        OP_STR  = 4'd7,
        OP_LDR  = 4'd8,
        OP_BEQ  = 4'd9,
        OP_JMP  = 4'd10,
        OP_CMP  = 4'd11,
        OP_ADDI = 4'd12,
        OP_ANDI = 4'd13,
        OP_SLR  = 4'd14
    } op_e;

    localparam int unsigned WORD_W = 9;

    localparam logic [3:0] OPC_MOV  = 4'b0000;
    localparam logic [3:0] OPC_ALU1 = 4'b0001;
    localparam logic [3:0] OPC_ALU2 = 4'b0010;
    localparam logic [3:0] OPC_ALU3 = 4'b0011;
    localparam logic [3:0] OPC_STR  = 4'b0110;
    localparam logic [3:0] OPC_LDR  = 4'b0111;
    localparam logic [3:0] OPC_CMP  = 4'b1010;
    localparam logic [3:0] OPC_ALU4 = 4'b1100;
    localparam logic [3:0] OPC_ADDI = 4'b1101;
    localparam logic [3:0] OPC_ANDI = 4'b1110;
    localparam logic [3:0] OPC_SLR  = 4'b1111;
    localparam logic [2:0] OPC_SHI  = 3'b010;
    localparam logic [2:0] OPC_BR   = 3'b100;

    localparam int unsigned W_R1   = 1;
    localparam int unsigned W_R2   = 2;
    localparam int unsigned W_R3   = 3;
    localparam int unsigned W_R4   = 4;
    localparam int unsigned W_IMM3 = 3;
    localparam int unsigned W_IMM5 = 5;

    // True when v has no bits set at or above position w.
    function automatic logic fits(input logic [7:0] v, input int unsigned w);
        return (v >> w) == 8'd0;
    endfunction

endpackage

// File: rtl/imem_encode_loader_if.sv
// Descriptor handshake from the program source plus the instruction-memory
// write port driven by the loader.
interface imem_encode_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_ra;
    logic [4:0]        in_rb;
    logic [7:0]        in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [8:0]        imem_wdata;

    modport master (
        output in_valid, in_op, in_ra, in_rb, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_ra, in_rb, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_pack.sv
// Combinational packer: symbolic op + fields -> 9-bit word and a legality
// flag; used fields must fit their encoded width, unused fields are ignored.
module instr_pack
    import isa_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic [4:0] ra_i,
    input  logic [4:0] rb_i,
    input  logic [7:0] imm_i,
    output logic [8:0] word_o,
    output logic       legal_o
);
    logic [7:0] ra_x, rb_x;

    assign ra_x = {3'b000, ra_i};
    assign rb_x = {3'b000, rb_i};

    always_comb begin
        word_o  = '0;
        legal_o = 1'b0;
        case (op_i)
            OP_MOV:  begin word_o = {OPC_MOV,  ra_i}; legal_o = 1'b1; end
            OP_ALU1: begin word_o = {OPC_ALU1, ra_i}; legal_o = 1'b1; end
            OP_ALU2: begin word_o = {OPC_ALU2, ra_i}; legal_o = 1'b1; end
            OP_ALU3: begin word_o = {OPC_ALU3, ra_i}; legal_o = 1'b1; end
            OP_ALU4: begin word_o = {OPC_ALU4, ra_i}; legal_o = 1'b1; end
            OP_SLI, OP_SRI: begin
                word_o  = {OPC_SHI, op_i == OP_SRI, ra_i[1:0], imm_i[2:0]};
                legal_o = fits(ra_x, W_R2) && fits(imm_i, W_IMM3);
            end
            OP_STR, OP_LDR: begin
                word_o  = {(op_i == OP_STR) ? OPC_STR : OPC_LDR, ra_i[3:0], rb_i[0]};
                legal_o = fits(ra_x, W_R4) && fits(rb_x, W_R1);
            end
            OP_BEQ, OP_JMP: begin
                word_o  = {OPC_BR, op_i == OP_JMP, imm_i[4:0]};
                legal_o = fits(imm_i, W_IMM5);
            end
            OP_CMP, OP_SLR: begin
                word_o  = {(op_i == OP_CMP) ? OPC_CMP : OPC_SLR, ra_i[1:0], rb_i[2:0]};
                legal_o = fits(ra_x, W_R2) && fits(rb_x, W_R3);
            end
            OP_ADDI, OP_ANDI: begin
                word_o  = {(op_i == OP_ADDI) ? OPC_ADDI : OPC_ANDI, imm_i[4:0]};
                legal_o = fits(imm_i, W_IMM5);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/imem_encode_loader.sv
// Program loader: packs accepted descriptors and streams them into imem from
// a programmable base. Build option ENC_CHECKSUM_EN adds a running word sum.
module imem_encode_loader
    import isa_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    imem_encode_loader_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_cnt,
    output logic              err,
    output logic              overflow,
    output logic [8:0]        checksum
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_ACC = CNT_W'(DEPTH - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [8:0]        wdata_q, wdata_d;
    logic              done_q, done_d;

    logic [8:0] word;
    logic       legal;
    logic       accept;

    instr_pack u_pack (
        .op_i    (bus.in_op),
        .ra_i    (bus.in_ra),
        .rb_i    (bus.in_rb),
        .imm_i   (bus.in_imm),
        .word_o  (word),
        .legal_o (legal)
    );

    assign bus.in_ready = (state_q == ST_LOAD);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path infers a latch.
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_LOAD;
                addr_d  = base_addr;
                cnt_d   = '0;
                acc_d   = '0;
                err_d   = 1'b0;
                ovf_d   = 1'b0;
            end
            ST_LOAD: begin
                if (accept) begin
                    // Illegal descriptors still spend budget but never write.
                    acc_d = acc_q + 1'b1;
                    if (legal) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = word;
                        addr_d  = addr_q + 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (acc_q == LAST_ACC) state_d = ST_FULL;
                end
                if (finish) state_d = ST_DRAIN;
            end
            ST_FULL: begin
                if (bus.in_valid) ovf_d = 1'b1;
                if (finish) state_d = ST_DRAIN;
            end
            default: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

`ifdef ENC_CHECKSUM_EN
    logic [8:0] csum_q, csum_d;

    // Sum tracks the output register, so it steps in the imem_we cycle.
    always_comb begin
        csum_d = csum_q;
        if (state_q == ST_IDLE && start) csum_d = '0;
        else if (we_d)                   csum_d = csum_q + wdata_d;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) csum_q <= '0;
        else          csum_q <= csum_d;
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy           = (state_q == ST_LOAD) || (state_q == ST_FULL);
    assign done           = done_q;
    assign word_cnt       = cnt_q;
    assign err            = err_q;
    assign overflow       = ovf_q;
endmodule
